imem_loader: RTL
================

# imem_loader

Boot-time program loader sitting directly upstream of the five-stage pipeline top. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory. It holds the pipeline in reset while loading and for a fixed drain period afterwards. It then releases the pipeline's reset and raises its start input.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words
- FLUSH_CYCLES, 5, cycles the core reset is held low after the last word is written (≥1)
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-low reset
- boot  input  1  single-cycle request to (re)start a load
- load_valid  input  1  load_data/load_last valid
- load_ready  output  1  loader accepts a beat this cycle
- load_data  input  32  instruction word
- load_last  input  1  marks final word of the program
- imem_we  output  1  instruction-memory write enable
- imem_addr  output  ADDR_W  word address of write
- imem_wdata  output  32  write data
- core_rst  output  1  active-low reset to pipeline top
- core_start  output  1  start to pipeline top
- load_done  output  1  program loaded, core running
- load_err  output  1  overflow: DEPTH words accepted without load_last
- word_count  output  ADDR_W+1  words written in current load

## Operation
- States: IDLE, LOAD, FLUSH, RUN, ERR. All outputs are registered or decoded from the state register only. There is no combinational path from load_valid to load_ready.
- Reset (rst=0 at an edge): state IDLE. imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, core_start=0, load_done=0, load_err=0, word_count=0, flush counter=0. Reset mid-load abandons the load; words already written remain in memory.
- IDLE: load_ready=0. boot=1 → LOAD.
- LOAD: load_ready=1.
  - A beat is accepted when load_valid && load_ready.
  - On accept: imem_we=1, imem_addr=word_count[ADDR_W-1:0] and imem_wdata=load_data are registered for one cycle; word_count increments.
  - Accept with load_last=1 → FLUSH, and the flush counter loads FLUSH_CYCLES.
  - Accept at word_count==DEPTH-1 with load_last=0 → ERR. That word is still written and word_count becomes DEPTH.
  - Accept at word_count==DEPTH-1 with load_last=1 → FLUSH (exactly full, no error).
  - No accept → imem_we=0.
- FLUSH: load_ready=0, core_rst=0. The counter decrements each cycle; at 1 → RUN.
- RUN: core_rst=1, core_start=1, load_done=1.
  - boot=1 → LOAD: next cycle core_rst=0, core_start=0, load_done=0, word_count=0.
- ERR: load_ready=0, load_err=1, core_rst=0.
  - boot=1 → LOAD with load_err=0 and word_count=0.
- boot is ignored in LOAD and FLUSH.
- load_data and load_last are ignored when load_valid=0.
- word_count is never cleared except by reset or boot.
- word_count holds its final value through FLUSH, RUN and ERR.

## Timing
- boot sampled at edge t → load_ready=1 in cycle t+1.
- Beat accepted at edge a → imem_we/addr/wdata valid in cycle a+1 (one-cycle write latency); word_count updated in cycle a+1.
- Last beat accepted at edge a:
  - load_ready=0 from cycle a+1.
  - FLUSH occupies cycles a+1 … a+FLUSH_CYCLES.
  - core_rst=1, core_start=1 and load_done=1 from cycle a+FLUSH_CYCLES+1.
- Back-to-back beats are sustained at one word per cycle; a stalled source (load_valid=0) simply inserts idle cycles.
- Simultaneous boot and rst=0: reset wins.

## Test plan
- Reset: hold rst=0 for 3 cycles with boot=1 → all outputs 0, state IDLE; release, pulse boot → load_ready=1 next cycle.
- Normal load: after boot, stream 4 words 0x00500093, 0x00300113, 0x002081B3, 0x00000013 with load_last on the 4th, load_valid=1 every cycle, FLUSH_CYCLES=5.
  - imem writes addr 0..3 with matching data on consecutive cycles.
  - word_count=4.
  - core_rst and core_start rise exactly 5 cycles after the cycle of the 4th write, together with load_done=1.
- Stalled source: same 4 words with load_valid low for 2 cycles between each beat → identical memory contents, imem_we only in the 4 accept+1 cycles, word_count=4.
- Overflow with ADDR_W=2: send 4 words with load_last never set → 4 writes to addr 0..3, then load_err=1, load_ready=0, word_count=4, core_rst stays 0. Exact-fit case with load_last on the 4th word → no error, RUN reached.
- Reload: in RUN pulse boot → next cycle core_rst=0, core_start=0, load_done=0, word_count=0, load_ready=1. A 2-word load then writes addr 0..1 and returns to RUN.
- Reset mid-load: assert rst=0 after 2 of 4 words accepted → next cycle load_ready=0, word_count=0, imem_we=0, state IDLE; subsequent boot restarts at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time program loader: streams instruction words into imem, holds the core
// in reset while loading plus a fixed drain period, then releases and starts it.
module imem_loader #(
    parameter int ADDR_W       = 10,
    parameter int FLUSH_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              core_start,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, ERR} state_t;

    state_t            state_q, state_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        word_count_d = word_count_q;
        flush_cnt_d  = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (boot) begin
                    state_d      = LOAD;
                    word_count_d = '0;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_count_q[ADDR_W-1:0];
                    imem_wdata_d = load_data;
                    word_count_d = word_count_q + 1'b1;
                    // load_last takes priority so an exactly-full program still runs
                    if (load_last) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FC_W'(FLUSH_CYCLES);
                    end else if (word_count_q == LAST_IDX) begin
                        state_d = ERR;
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - 1'b1;
                if (flush_cnt_q == FC_W'(1)) begin
                    state_d = RUN;
                end
            end
            RUN, ERR: begin
                if (boot) begin
                    state_d      = LOAD;
                    word_count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            word_count_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            word_count_q <= word_count_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Handshake and core controls decode from state only: no valid-to-ready path.
    assign load_ready = (state_q == LOAD);
    assign core_rst   = (state_q == RUN);
    assign core_start = (state_q == RUN);
    assign load_done  = (state_q == RUN);
    assign load_err   = (state_q == ERR);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign word_count = word_count_q;

endmodule
